// File: rtl/i2c_poll_sequencer.sv
// Poll sequencer for the I2C world top: launches read rounds, tags and
// buffers returned bytes in a show-ahead FIFO, tracks timeouts and drops.
module i2c_poll_sequencer #(
  parameter logic [15:0] POLL_INTERVAL = 16'd1000,
  parameter logic [15:0] TIMEOUT       = 16'd50000,
  parameter int          DEPTH_LOG2    = 2
) (
  input  logic        clk,
  input  logic        arst_i,
  input  logic        enable,
  output logic        w_start,
  input  logic        w_domain,
  input  logic [7:0]  w_rd_data,
  input  logic        w_valid,
  input  logic        w_done,
  output logic [7:0]  out_data,
  output logic        out_domain,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        timeout,
  input  logic        clr_status,
  output logic [15:0] frame_cnt
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;
  localparam logic [15:0] GAP_LAST = POLL_INTERVAL - 16'd1;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_e;

  state_e              state_q;
  logic [15:0]         wait_q;
  logic [15:0]         gap_q;
  logic [15:0]         frame_q;
  logic                ovf_q;
  logic                tmo_q;
  logic [DEPTH_LOG2:0] wr_q;
  logic [DEPTH_LOG2:0] rd_q;
  logic [8:0]          mem_q [DEPTH];

  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       wr_en;
  logic [8:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                 (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
  assign push  = (state_q == WAIT) && w_valid;
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a byte when the head leaves the same cycle.
  assign wr_en = push && (!full || pop);
  assign head  = mem_q[rd_q[DEPTH_LOG2-1:0]];

  assign w_start    = (state_q == START);
  assign out_valid  = !empty;
  assign out_data   = empty ? 8'h00 : head[7:0];
  assign out_domain = empty ? 1'b0 : head[8];
  assign overflow   = ovf_q;
  assign timeout    = tmo_q;
  assign frame_cnt  = frame_q;

  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      gap_q   <= '0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (clr_status) begin
        ovf_q <= 1'b0;
        tmo_q <= 1'b0;
      end
      if (push && full && !pop) ovf_q <= 1'b1;
      unique case (state_q)
        IDLE: if (enable) state_q <= START;
        START: begin
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wait_q <= wait_q + 16'd1;
          if (w_done) begin
            frame_q <= frame_q + 16'd1;
            gap_q   <= '0;
            state_q <= GAP;
          end else if (wait_q == TMO_LAST) begin
            tmo_q   <= 1'b1;
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          gap_q <= gap_q + 16'd1;
          if (gap_q == GAP_LAST) state_q <= enable ? START : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + PTR_ONE;
      if (pop)   rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[DEPTH_LOG2-1:0]] <= {w_domain, w_rd_data};
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Directed bench for i2c_poll_sequencer: rounds, FIFO limits,
// timeout, asynchronous reset and enable handling.
module tb_i2c_poll_sequencer;

  localparam int P = 8;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        enable = 1'b0;
  logic        w_start;
  logic        w_domain = 1'b0;
  logic [7:0]  w_rd_data = 8'h00;
  logic        w_valid = 1'b0;
  logic        w_done = 1'b0;
  logic [7:0]  out_data;
  logic        out_domain;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        timeout;
  logic        clr_status = 1'b0;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  i2c_poll_sequencer #(
    .POLL_INTERVAL(16'd8),
    .TIMEOUT      (16'd100),
    .DEPTH_LOG2   (2)
  ) dut (
    .clk       (clk),
    .arst_i    (arst_i),
    .enable    (enable),
    .w_start   (w_start),
    .w_domain  (w_domain),
    .w_rd_data (w_rd_data),
    .w_valid   (w_valid),
    .w_done    (w_done),
    .out_data  (out_data),
    .out_domain(out_domain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .timeout   (timeout),
    .clr_status(clr_status),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_reset();
    enable = 0; out_ready = 0; clr_status = 0;
    w_valid = 0; w_done = 0; w_domain = 0; w_rd_data = 0;
    @(negedge clk);
    arst_i = 0;
    repeat (2) @(negedge clk);
    arst_i = 1;
  endtask

  // Waits (bounded) for the next w_start; returns its cycle index or -1.
  task automatic wait_start(input string nm, output int c);
    c = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (w_start) begin
        c = cyc;
        break;
      end
    end
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL %s no w_start seen within 300 cycles", nm);
    end
  endtask

  // Drives one world-top cycle, sampled at the following rising edge.
  task automatic drive(input logic v, input logic dom,
                       input logic [7:0] d, input logic dn);
    w_valid = v; w_domain = dom; w_rd_data = d; w_done = dn;
    @(negedge clk);
    w_valid = 0; w_domain = 0; w_rd_data = 0; w_done = 0;
  endtask

  task automatic test_reset();
    #3 arst_i = 0;
    #1;
    checks++;
    if ({w_start, out_valid, out_domain, overflow, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {w_start, out_valid, out_domain, overflow, timeout});
    end
    checks++;
    if ({frame_cnt, out_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 000000", {frame_cnt, out_data});
    end
    repeat (2) @(negedge clk);
    arst_i = 1;
  endtask

  task automatic test_normal_round();
    int s, s2, d;
    apply_reset();
    enable = 1; out_ready = 1;
    wait_start("normal_start", s);
    @(negedge clk);
    checks++;
    if (w_start !== 1'b0) begin
      errors++;
      $display("FAIL normal_single_pulse got %b exp 0", w_start);
    end
    drive(1, 0, 8'h12, 0);
    checks++;
    if ({out_valid, out_domain, out_data} !== 10'b1_0_0001_0010) begin
      errors++;
      $display("FAIL normal_byte0 got %b exp 1000010010",
               {out_valid, out_domain, out_data});
    end
    d = cyc;
    drive(1, 1, 8'h90, 1);
    checks++;
    if ({out_valid, out_domain, out_data} !== 10'b1_1_1001_0000) begin
      errors++;
      $display("FAIL normal_byte1 got %b exp 1110010000",
               {out_valid, out_domain, out_data});
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL normal_frame_cnt got %0d exp 1", frame_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_drained got %b exp 0", out_valid);
    end
    wait_start("normal_restart", s2);
    checks++;
    if (s2 - d !== P + 1) begin
      errors++;
      $display("FAIL normal_gap got %0d exp %0d", s2 - d, P + 1);
    end
  endtask

  task automatic test_overflow();
    int s, n;
    logic [8:0] exp_q [4];
    exp_q[0] = 9'h001; exp_q[1] = 9'h102;
    exp_q[2] = 9'h003; exp_q[3] = 9'h104;
    apply_reset();
    enable = 1; out_ready = 0;
    for (int r = 0; r < 3; r++) begin
      wait_start("ovf_start", s);
      @(negedge clk);
      drive(1, 0, 8'(2 * r + 1), 0);
      if (r == 2) begin
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set got %b exp 1", overflow);
        end
        enable = 0;
      end
      drive(1, 1, 8'(2 * r + 2), 1);
      if (r == 1) begin
        checks++;
        if ({overflow, out_valid, out_domain, out_data} !== 11'b0_1_0_0000_0001) begin
          errors++;
          $display("FAIL ovf_full_head got %b exp 01000000001",
                   {overflow, out_valid, out_domain, out_data});
        end
      end
    end
    out_ready = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        checks++;
        if (n > 3 || {out_domain, out_data} !== exp_q[n & 3]) begin
          errors++;
          $display("FAIL ovf_drain%0d got %h exp %h", n,
                   {out_domain, out_data}, exp_q[n & 3]);
        end
        n++;
      end
      @(negedge clk);
    end
    out_ready = 0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ovf_drain_count got %0d exp 4", n);
    end
    clr_status = 1;
    @(negedge clk);
    clr_status = 0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b exp 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int s, n;
    logic [8:0] exp_q [4];
    exp_q[0] = 9'h022; exp_q[1] = 9'h033;
    exp_q[2] = 9'h044; exp_q[3] = 9'h1AA;
    apply_reset();
    enable = 1; out_ready = 0;
    wait_start("fpp_start", s);
    @(negedge clk);
    drive(1, 0, 8'h11, 0);
    drive(1, 0, 8'h22, 0);
    drive(1, 0, 8'h33, 0);
    drive(1, 0, 8'h44, 0);
    out_ready = 1;
    drive(1, 1, 8'hAA, 0);
    out_ready = 0;
    checks++;
    if ({overflow, out_valid, out_domain, out_data} !== 11'b0_1_0_0010_0010) begin
      errors++;
      $display("FAIL fpp_head got %b exp 01000100010",
               {overflow, out_valid, out_domain, out_data});
    end
    out_ready = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        checks++;
        if (n > 3 || {out_domain, out_data} !== exp_q[n & 3]) begin
          errors++;
          $display("FAIL fpp_drain%0d got %h exp %h", n,
                   {out_domain, out_data}, exp_q[n & 3]);
        end
        n++;
      end
      @(negedge clk);
    end
    out_ready = 0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL fpp_count got %0d exp 4", n);
    end
  endtask

  task automatic test_timeout();
    int s, s2, t;
    apply_reset();
    enable = 1; out_ready = 1;
    wait_start("tmo_start", s);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t - s !== T + 1) begin
      errors++;
      $display("FAIL tmo_latency got %0d exp %0d", t - s, T + 1);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL tmo_frame_cnt got %0d exp 0", frame_cnt);
    end
    wait_start("tmo_restart", s2);
    checks++;
    if (s2 - s !== T + P + 1) begin
      errors++;
      $display("FAIL tmo_restart got %0d exp %0d", s2 - s, T + P + 1);
    end
  endtask

  task automatic test_done_on_timeout();
    int s;
    apply_reset();
    enable = 1;
    wait_start("dot_start", s);
    repeat (T) @(negedge clk);
    drive(0, 0, 8'h00, 1);
    checks++;
    if ({timeout, frame_cnt} !== 17'd1) begin
      errors++;
      $display("FAIL dot_done_wins got tmo=%b cnt=%0d exp tmo=0 cnt=1",
               timeout, frame_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    int s, seen;
    apply_reset();
    enable = 1; out_ready = 0;
    wait_start("rst_start1", s);
    @(negedge clk);
    drive(0, 0, 8'h00, 1);
    wait_start("rst_start2", s);
    @(negedge clk);
    drive(1, 0, 8'hB1, 0);
    drive(1, 1, 8'hB2, 0);
    checks++;
    if ({out_valid, frame_cnt} !== 17'h1_0001) begin
      errors++;
      $display("FAIL rst_pre got %h exp 10001", {out_valid, frame_cnt});
    end
    #2;
    arst_i = 0; enable = 0;
    #1;
    checks++;
    if ({w_start, out_valid, out_domain, overflow, timeout,
         out_data, frame_cnt} !== 29'h0) begin
      errors++;
      $display("FAIL rst_async got v=%b d=%h cnt=%0d exp all zero",
               out_valid, out_data, frame_cnt);
    end
    repeat (2) @(negedge clk);
    arst_i = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_start) seen++;
    end
    checks++;
    if (seen !== 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got starts=%0d v=%b exp 0 0", seen, out_valid);
    end
  endtask

  task automatic test_enable_drop();
    int s, seen;
    apply_reset();
    enable = 1; out_ready = 1;
    wait_start("endrop_start", s);
    @(negedge clk);
    enable = 0;
    drive(1, 1, 8'h5A, 1);
    checks++;
    if ({frame_cnt, out_valid, out_domain, out_data} !== 26'h0_0007_5A) begin
      errors++;
      $display("FAIL endrop_round got cnt=%0d v=%b d=%h exp 1 1 15a",
               frame_cnt, out_valid, {out_domain, out_data});
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (w_start) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL endrop_no_start got %0d exp 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_done_on_timeout();
    test_reset_mid_wait();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
